// File: rtl/adpcm_playback_fifo.sv
// Stereo playback buffer between the ADPCM decoder and the mixer: per-channel sample FIFOs,
// fixed-rate frame release, mono duplication and 2x linear interpolation for half-rate coding.
module adpcm_playback_fifo #(
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [15:0]         in_sample,
  input  logic                in_write,
  output logic                in_strobe,
  input  logic                in_channel,
  input  logic                coding_mono,
  input  logic                coding_half,
  input  logic                flush,
  input  logic                sample_tick,
  output logic [15:0]         out_left,
  output logic [15:0]         out_right,
  output logic                out_valid,
  output logic                underrun,
  output logic [DEPTH_LOG2:0] level
);

  localparam int                    DEPTH    = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = {(DEPTH_LOG2 + 1){1'b0}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [15:0]           mem_l_q [DEPTH];
  logic [15:0]           mem_r_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_l_q, wr_l_d, rd_l_q, rd_l_d;
  logic [DEPTH_LOG2-1:0] wr_r_q, wr_r_d, rd_r_q, rd_r_d;
  logic [DEPTH_LOG2:0]   cnt_l_q, cnt_l_d, cnt_r_q, cnt_r_d;
  logic                  strobe_q, strobe_d;
  logic [15:0]           out_l_q, out_l_d, out_r_q, out_r_d;
  logic [15:0]           prev_l_q, prev_l_d, prev_r_q, prev_r_d;
  logic                  valid_q, valid_d;
  logic                  under_q, under_d;
  logic                  phase_q, phase_d;

  logic                  empty_l_s, empty_r_s, frame_s, pop_s;
  logic                  push_l_s, push_r_s, space_l_s, space_r_s, space_ok_s;
  logic [15:0]           head_l_s, head_r_s, interp_l_s, interp_r_s;
  logic [16:0]           sum_l_s, sum_r_s;

  // Occupancy, handshake and pop/push decisions.
  always_comb begin
    empty_l_s  = (cnt_l_q == CNT_ZERO);
    empty_r_s  = (cnt_r_q == CNT_ZERO);
    frame_s    = !empty_l_s && !empty_r_s;
    pop_s      = sample_tick && !flush && frame_s && !(coding_half && phase_q);
    push_l_s   = strobe_q && !flush && (coding_mono || !in_channel);
    push_r_s   = strobe_q && !flush && (coding_mono || in_channel);
    // A full FIFO popping this cycle has room by the time the strobe cycle writes.
    space_l_s  = (cnt_l_q != CNT_FULL) || pop_s;
    space_r_s  = (cnt_r_q != CNT_FULL) || pop_s;
    if (coding_mono) begin
      space_ok_s = space_l_s && space_r_s;
    end else if (in_channel) begin
      space_ok_s = space_r_s;
    end else begin
      space_ok_s = space_l_s;
    end
    strobe_d   = in_write && !strobe_q && !flush && space_ok_s;
    head_l_s   = mem_l_q[rd_l_q];
    head_r_s   = mem_r_q[rd_r_q];
    sum_l_s    = {prev_l_q[15], prev_l_q} + {head_l_s[15], head_l_s};
    sum_r_s    = {prev_r_q[15], prev_r_q} + {head_r_s[15], head_r_s};
    interp_l_s = sum_l_s[16:1];
    interp_r_s = sum_r_s[16:1];
  end

  // Pointer and occupancy next state.
  always_comb begin
    if (flush) begin
      wr_l_d  = PTR_ZERO;
      rd_l_d  = PTR_ZERO;
      wr_r_d  = PTR_ZERO;
      rd_r_d  = PTR_ZERO;
      cnt_l_d = CNT_ZERO;
      cnt_r_d = CNT_ZERO;
    end else begin
      wr_l_d = push_l_s ? (wr_l_q + PTR_ONE) : wr_l_q;
      wr_r_d = push_r_s ? (wr_r_q + PTR_ONE) : wr_r_q;
      rd_l_d = pop_s ? (rd_l_q + PTR_ONE) : rd_l_q;
      rd_r_d = pop_s ? (rd_r_q + PTR_ONE) : rd_r_q;
      case ({push_l_s, pop_s})
        2'b10:   cnt_l_d = cnt_l_q + CNT_ONE;
        2'b01:   cnt_l_d = cnt_l_q - CNT_ONE;
        default: cnt_l_d = cnt_l_q;
      endcase
      case ({push_r_s, pop_s})
        2'b10:   cnt_r_d = cnt_r_q + CNT_ONE;
        2'b01:   cnt_r_d = cnt_r_q - CNT_ONE;
        default: cnt_r_d = cnt_r_q;
      endcase
    end
  end

  // Output frame, interpolation phase and underrun next state.
  always_comb begin
    out_l_d  = out_l_q;
    out_r_d  = out_r_q;
    prev_l_d = prev_l_q;
    prev_r_d = prev_r_q;
    valid_d  = 1'b0;
    under_d  = under_q;
    phase_d  = phase_q;
    if (flush) begin
      out_l_d = 16'h0000;
      out_r_d = 16'h0000;
      under_d = 1'b0;
      phase_d = 1'b0;
    end else if (sample_tick) begin
      valid_d = 1'b1;
      if (coding_half && phase_q) begin
        out_l_d = empty_l_s ? prev_l_q : interp_l_s;
        out_r_d = empty_r_s ? prev_r_q : interp_r_s;
        phase_d = 1'b0;
      end else if (frame_s) begin
        out_l_d  = head_l_s;
        out_r_d  = head_r_s;
        prev_l_d = head_l_s;
        prev_r_d = head_r_s;
        phase_d  = coding_half;
      end else begin
        under_d = 1'b1;
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // Sample storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_l_s) mem_l_q[wr_l_q] <= in_sample;
    if (push_r_s) mem_r_q[wr_r_q] <= in_sample;
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_l_q   <= PTR_ZERO;
      rd_l_q   <= PTR_ZERO;
      wr_r_q   <= PTR_ZERO;
      rd_r_q   <= PTR_ZERO;
      cnt_l_q  <= CNT_ZERO;
      cnt_r_q  <= CNT_ZERO;
      strobe_q <= 1'b0;
      out_l_q  <= 16'h0000;
      out_r_q  <= 16'h0000;
      prev_l_q <= 16'h0000;
      prev_r_q <= 16'h0000;
      valid_q  <= 1'b0;
      under_q  <= 1'b0;
      phase_q  <= 1'b0;
    end else begin
      wr_l_q   <= wr_l_d;
      rd_l_q   <= rd_l_d;
      wr_r_q   <= wr_r_d;
      rd_r_q   <= rd_r_d;
      cnt_l_q  <= cnt_l_d;
      cnt_r_q  <= cnt_r_d;
      strobe_q <= strobe_d;
      out_l_q  <= out_l_d;
      out_r_q  <= out_r_d;
      prev_l_q <= prev_l_d;
      prev_r_q <= prev_r_d;
      valid_q  <= valid_d;
      under_q  <= under_d;
      phase_q  <= phase_d;
    end
  end

  assign in_strobe = strobe_q;
  assign out_left  = out_l_q;
  assign out_right = out_r_q;
  assign out_valid = valid_q;
  assign underrun  = under_q;
  assign level     = cnt_l_q;

endmodule

// File: tb/tb_adpcm_playback_fifo.sv
// Directed bench for adpcm_playback_fifo: inputs driven and outputs sampled on the falling edge.
module tb_adpcm_playback_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] in_sample;
  logic        in_write, in_strobe, in_channel, coding_mono, coding_half;
  logic        flush, sample_tick;
  logic [15:0] out_left, out_right;
  logic        out_valid, underrun;
  logic [5:0]  level;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  adpcm_playback_fifo #(.DEPTH_LOG2(5)) dut (
    .clk(clk), .reset_n(reset_n), .in_sample(in_sample), .in_write(in_write),
    .in_strobe(in_strobe), .in_channel(in_channel), .coding_mono(coding_mono),
    .coding_half(coding_half), .flush(flush), .sample_tick(sample_tick),
    .out_left(out_left), .out_right(out_right), .out_valid(out_valid),
    .underrun(underrun), .level(level)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic push(input logic ch, input logic [15:0] v);
    bit got = 1'b0;
    @(negedge clk);
    in_channel = ch;
    in_sample  = v;
    in_write   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_strobe) begin
        got = 1'b1;
        break;
      end
    end
    @(negedge clk);
    in_write = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL push_strobe: in_strobe=0 after 20 cycles, required 1");
    end
  endtask

  task automatic do_tick();
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({out_left, out_right} !== 32'h0) begin
      errors++; $display("FAIL reset_out: got %h/%h, required 0/0", out_left, out_right);
    end
    checks++;
    if ({out_valid, underrun, in_strobe} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got valid=%b under=%b strobe=%b, required 0", out_valid, underrun, in_strobe);
    end
    checks++;
    if (level !== 6'd0) begin
      errors++; $display("FAIL reset_level: got %0d, required 0", level);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_stereo();
    coding_mono = 1'b0;
    coding_half = 1'b0;
    push(1'b0, 16'd100);
    push(1'b1, 16'hFF9C);
    push(1'b0, 16'd200);
    push(1'b1, 16'hFF38);
    checks++;
    if (level !== 6'd2) begin
      errors++; $display("FAIL stereo_level: got %0d, required 2", level);
    end
    do_tick();
    checks++;
    if (out_valid !== 1'b1 || out_left !== 16'd100 || out_right !== 16'hFF9C) begin
      errors++; $display("FAIL stereo_frame1: got v=%b %0d/%0d, required 1 100/-100", out_valid, $signed(out_left), $signed(out_right));
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL stereo_valid_pulse: got %b, required 0", out_valid);
    end
    do_tick();
    checks++;
    if (out_valid !== 1'b1 || out_left !== 16'd200 || out_right !== 16'hFF38 || underrun !== 1'b0) begin
      errors++; $display("FAIL stereo_frame2: got v=%b %0d/%0d u=%b, required 1 200/-200 0", out_valid, $signed(out_left), $signed(out_right), underrun);
    end
  endtask

  task automatic test_mono();
    coding_mono = 1'b1;
    do_flush();
    for (int k = 1; k <= 5; k++) push(1'b0, 16'(k));
    checks++;
    if (level !== 6'd5) begin
      errors++; $display("FAIL mono_level: got %0d, required 5", level);
    end
    for (int k = 1; k <= 5; k++) begin
      do_tick();
      checks++;
      if (out_left !== 16'(k) || out_right !== 16'(k)) begin
        errors++; $display("FAIL mono_out%0d: got %0d/%0d, required %0d/%0d", k, $signed(out_left), $signed(out_right), k, k);
      end
    end
  endtask

  task automatic test_half_rate();
    logic [15:0] exp_v [5];
    exp_v[0] = 16'd0; exp_v[1] = 16'd50; exp_v[2] = 16'd100; exp_v[3] = 16'hFFFF; exp_v[4] = 16'hFF9B;
    coding_mono = 1'b1;
    do_flush();
    coding_half = 1'b1;
    push(1'b0, 16'd0);
    push(1'b0, 16'd100);
    push(1'b0, 16'hFF9B);
    for (int k = 0; k < 5; k++) begin
      do_tick();
      checks++;
      if (out_valid !== 1'b1 || out_left !== exp_v[k] || out_right !== exp_v[k]) begin
        errors++; $display("FAIL half_out%0d: got v=%b %0d/%0d, required 1 %0d", k, out_valid, $signed(out_left), $signed(out_right), $signed(exp_v[k]));
      end
    end
    coding_half = 1'b0;
  endtask

  task automatic test_full();
    int  n = 0;
    int  n2 = 0;
    bit  pend = 1'b0;
    coding_mono = 1'b1;
    do_flush();
    @(negedge clk);
    in_sample = 16'd1000;
    in_write  = 1'b1;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      if (pend) begin in_sample = 16'(1000 + n); pend = 1'b0; end
      if (in_strobe) begin n++; pend = 1'b1; end
    end
    checks++;
    if (n != 32 || level !== 6'd32) begin
      errors++; $display("FAIL full_strobes: got %0d strobes level %0d, required 32 and 32", n, level);
    end
    sample_tick = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) begin
        sample_tick = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_left !== 16'd1000) begin
          errors++; $display("FAIL full_pop: got v=%b %0d, required 1 1000", out_valid, out_left);
        end
      end
      if (in_strobe) n2++;
    end
    checks++;
    if (n2 != 1 || level !== 6'd32) begin
      errors++; $display("FAIL full_refill: got %0d strobes level %0d, required 1 and 32", n2, level);
    end
    in_write = 1'b0;
    do_flush();
    checks++;
    if (level !== 6'd0) begin
      errors++; $display("FAIL full_flush_level: got %0d, required 0", level);
    end
  endtask

  task automatic test_underrun();
    coding_mono = 1'b0;
    do_flush();
    push(1'b0, 16'd7);
    push(1'b1, 16'd8);
    for (int k = 0; k < 3; k++) begin
      do_tick();
      checks++;
      if (out_valid !== 1'b1 || out_left !== 16'd7 || out_right !== 16'd8 || underrun !== (k != 0)) begin
        errors++; $display("FAIL underrun_tick%0d: got v=%b %0d/%0d u=%b, required 1 7/8 u=%0d", k, out_valid, out_left, out_right, underrun, k != 0);
      end
    end
    do_flush();
    checks++;
    if (underrun !== 1'b0 || out_left !== 16'd0 || out_right !== 16'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL underrun_flush: got u=%b %0d/%0d v=%b, required 0 0/0 0", underrun, out_left, out_right, out_valid);
    end
  endtask

  task automatic test_async_reset();
    int  n = 0;
    bit  got = 1'b0;
    coding_mono = 1'b1;
    do_flush();
    push(1'b0, 16'd11);
    push(1'b0, 16'd12);
    push(1'b0, 16'd13);
    do_tick();
    checks++;
    if (out_left !== 16'd11 || level !== 6'd2) begin
      errors++; $display("FAIL areset_pre: got %0d level %0d, required 11 level 2", out_left, level);
    end
    @(negedge clk);
    in_sample = 16'd14;
    in_write  = 1'b1;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (level !== 6'd0 || out_left !== 16'd0 || out_right !== 16'd0 || in_strobe !== 1'b0) begin
      errors++; $display("FAIL areset_immediate: got level %0d out %0d/%0d strobe %b, required 0 0/0 0", level, out_left, out_right, in_strobe);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (in_strobe) n++;
    end
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL areset_no_strobe: got %0d strobes, required 0", n);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_strobe) begin got = 1'b1; break; end
    end
    @(negedge clk);
    in_write = 1'b0;
    checks++;
    if (!got || level !== 6'd1) begin
      errors++; $display("FAIL areset_resume: got strobe=%b level %0d, required 1 level 1", got, level);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    in_sample   = 16'd0;
    in_write    = 1'b0;
    in_channel  = 1'b0;
    coding_mono = 1'b0;
    coding_half = 1'b0;
    flush       = 1'b0;
    sample_tick = 1'b0;
    test_reset();
    test_stereo();
    test_mono();
    test_half_rate();
    test_full();
    test_underrun();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
